// File: rtl/jt89_mixer.sv
// Serial 4-channel gain mixer for jt89 outputs: snapshot, one shared MAC, saturated 16-bit sample.
// Optional one-pole smoothing filter is enabled by defining JT89_MIX_LPF_EN.
module jt89_mixer #(
    parameter int SHIFT = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cen,
    input  logic signed [9:0]  ch0,
    input  logic signed [9:0]  ch1,
    input  logic signed [9:0]  ch2,
    input  logic signed [9:0]  noise,
    input  logic        [7:0]  gain0,
    input  logic        [7:0]  gain1,
    input  logic        [7:0]  gain2,
    input  logic        [7:0]  gain3,
    output logic signed [15:0] out,
    output logic               sample,
    output logic               peak
);

    typedef enum logic [2:0] {
        SNAP,
        MAC0,
        MAC1,
        MAC2,
        MAC3
`ifdef JT89_MIX_LPF_EN
        , FILT
`endif
    } state_t;

    state_t state_q, state_d;

    logic signed [9:0]  ch_q   [4];
    logic        [7:0]  gain_q [4];
    logic signed [19:0] acc_q, acc_d;
    logic signed [15:0] out_q;
    logic               sample_q, peak_q;

    logic        [1:0]  sel;
    logic               snap_en, mac_en, mac_last, emit;
    logic signed [17:0] prod;
    logic signed [19:0] sum, res;
    logic signed [15:0] sat;
    logic               clip;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= SNAP;
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        else        state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        // NOTE: default first so no path leaves state_d unassigned (no latch).
        state_d = state_q;
        if (cen) begin
            unique case (state_q)
                SNAP:    state_d = MAC0;
                MAC0:    state_d = MAC1;
                MAC1:    state_d = MAC2;
                MAC2:    state_d = MAC3;
`ifdef JT89_MIX_LPF_EN
                MAC3:    state_d = FILT;
                FILT:    state_d = SNAP;
`else
                MAC3:    state_d = SNAP;
`endif
                default: state_d = SNAP;
            endcase
        end
    end

    // ---------------- FSM: decoded controls ----------------
    always_comb begin
        snap_en  = 1'b0;
        mac_en   = 1'b0;
        mac_last = 1'b0;
        emit     = 1'b0;
        sel      = 2'd0;
        unique case (state_q)
            SNAP: snap_en = 1'b1;
            MAC0: begin mac_en = 1'b1; sel = 2'd0; end
            MAC1: begin mac_en = 1'b1; sel = 2'd1; end
            MAC2: begin mac_en = 1'b1; sel = 2'd2; end
            MAC3: begin
                mac_en   = 1'b1;
                mac_last = 1'b1;
                sel      = 2'd3;
`ifndef JT89_MIX_LPF_EN
                emit     = 1'b1;
`endif
            end
`ifdef JT89_MIX_LPF_EN
            FILT: emit = 1'b1;
`endif
            default: snap_en = 1'b0;
        endcase
    end

    // ---------------- Datapath ----------------
    // Gain is zero-extended so 255 stays positive; 18-bit product cannot overflow.
    assign prod = $signed({{8{ch_q[sel][9]}}, ch_q[sel]}) * $signed({10'd0, gain_q[sel]});
    assign sum  = acc_q + {{2{prod[17]}}, prod};
    assign res  = sum >>> SHIFT;

    always_comb begin
        acc_d = acc_q;
        if (snap_en)     acc_d = '0;
        else if (mac_en) acc_d = sum;
    end

    always_comb begin
        clip = 1'b1;
        if (res > 20'sd32767)       sat = 16'sh7fff;
        else if (res < -20'sd32768) sat = 16'sh8000;
        else begin
            sat  = res[15:0];
            clip = 1'b0;
        end
    end

`ifdef JT89_MIX_LPF_EN
    logic signed [15:0] x_q;
    logic               clip_q;
    logic signed [17:0] y_q, y_d;
    logic signed [18:0] diff, step;

    assign diff = {{3{x_q[15]}}, x_q} - {y_q[17], y_q};
    assign step = diff >>> 2;
    assign y_d  = y_q + step[17:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: snapshot arrays are small flops, not RAM, so they are cleared with the rest.
            for (int i = 0; i < 4; i++) begin
                ch_q[i]   <= '0;
                gain_q[i] <= '0;
            end
            acc_q    <= '0;
            out_q    <= '0;
            sample_q <= 1'b0;
            peak_q   <= 1'b0;
`ifdef JT89_MIX_LPF_EN
            x_q      <= '0;
            clip_q   <= 1'b0;
            y_q      <= '0;
`endif
        end else if (cen) begin
            if (snap_en) begin
                ch_q[0]   <= ch0;
                ch_q[1]   <= ch1;
                ch_q[2]   <= ch2;
                ch_q[3]   <= noise;
                gain_q[0] <= gain0;
                gain_q[1] <= gain1;
                gain_q[2] <= gain2;
                gain_q[3] <= gain3;
            end
            acc_q    <= acc_d;
            sample_q <= emit;
`ifdef JT89_MIX_LPF_EN
            if (mac_last) begin
                x_q    <= sat;
                clip_q <= clip;
            end
            if (emit) begin
                y_q   <= y_d;
                out_q <= y_d[15:0];
            end
            peak_q <= emit & clip_q;
`else
            if (mac_last) out_q <= sat;
            peak_q <= emit & clip;
`endif
        end
    end

    // Strobes show on the first enabled clk after the update, so they never assert while cen=0.
    assign out    = out_q;
    assign sample = sample_q & cen;
    assign peak   = peak_q & cen;

endmodule

// File: tb/tb_jt89_mixer.sv
// Self-checking bench for jt89_mixer: frame-aligned scenarios plus a scoreboard fed at each snapshot.
module tb_jt89_mixer;

    localparam int SHIFT = 2;
`ifdef JT89_MIX_LPF_EN
    localparam int FRAME = 6;
`else
    localparam int FRAME = 5;
`endif

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               cen = 1'b1;
    logic signed [9:0]  ch0 = '0, ch1 = '0, ch2 = '0, noise = '0;
    logic        [7:0]  gain0 = '0, gain1 = '0, gain2 = '0, gain3 = '0;
    logic signed [15:0] out;
    logic               sample, peak;

    int checks   = 0;
    int failures = 0;
    int cen_mode = 0;
    int cen_cnt  = 0;

    typedef struct {
        int val;
        bit pk;
    } exp_t;
    exp_t sb[$];

    jt89_mixer #(.SHIFT(SHIFT)) dut (
        .clk(clk), .rst_n(rst_n), .cen(cen),
        .ch0(ch0), .ch1(ch1), .ch2(ch2), .noise(noise),
        .gain0(gain0), .gain1(gain1), .gain2(gain2), .gain3(gain3),
        .out(out), .sample(sample), .peak(peak)
    );

    always #5 clk = ~clk;

    // cen pattern: continuous, or one clk in three
    always @(posedge clk) begin
        #1;
        if (cen_mode == 0) cen = 1'b1;
        else begin
            cen     = (cen_cnt == 0);
            cen_cnt = (cen_cnt + 1) % 3;
        end
    end

    // Reference model: computes the expected sample at each snapshot edge
    int mdl_ph = 0;
    int mdl_y  = 0;
    always @(posedge clk or negedge rst_n) begin
        int   s, r, x;
        bit   c;
        exp_t e;
        if (!rst_n) begin
            mdl_ph = 0;
            mdl_y  = 0;
            sb.delete();
        end else if (cen) begin
            if (mdl_ph == 0) begin
                s = int'(ch0) * int'(gain0) + int'(ch1) * int'(gain1)
                  + int'(ch2) * int'(gain2) + int'(noise) * int'(gain3);
                r = s >>> SHIFT;
                c = 1'b1;
                if (r > 32767)       x = 32767;
                else if (r < -32768) x = -32768;
                else begin
                    x = r;
                    c = 1'b0;
                end
`ifdef JT89_MIX_LPF_EN
                mdl_y = mdl_y + ((x - mdl_y) >>> 2);
                e.val = mdl_y;
`else
                e.val = x;
`endif
                e.pk = c;
                sb.push_back(e);
            end
            mdl_ph = (mdl_ph + 1) % FRAME;
        end
    end

    // Scoreboard consumer and strobe sanity
    always @(negedge clk) begin
        exp_t e;
        if (sample === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected: sample with no expected entry, out=%0d", out);
            end else begin
                e = sb.pop_front();
                if (out !== 16'(e.val) || peak !== e.pk) begin
                    failures++;
                    $display("FAIL sb_sample: out=%0d peak=%0b expected out=%0d peak=%0b",
                             out, peak, e.val, e.pk);
                end
            end
        end else begin
            checks++;
            if (peak !== 1'b0) begin
                failures++;
                $display("FAIL peak_without_sample: peak=%0b expected 0", peak);
            end
        end
        if (cen === 1'b0) begin
            checks++;
            if (sample !== 1'b0) begin
                failures++;
                $display("FAIL sample_while_cen_low: sample=%0b expected 0", sample);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic set_inputs(input int c0, input int c1, input int c2, input int cn,
                              input int g0, input int g1, input int g2, input int g3);
        ch0   = 10'(c0);
        ch1   = 10'(c1);
        ch2   = 10'(c2);
        noise = 10'(cn);
        gain0 = 8'(g0);
        gain1 = 8'(g1);
        gain2 = 8'(g2);
        gain3 = 8'(g3);
    endtask

    // Returns at the negedge where sample is seen; n counts posedges waited
    task automatic wait_sample(output bit ok, output int n);
        ok = 1'b0;
        n  = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (sample === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bit ok;
        int n;
        int exp_first;
        rst_n    = 1'b0;
        cen_mode = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            set_inputs($urandom_range(1023), $urandom_range(1023), $urandom_range(1023),
                       $urandom_range(1023), $urandom_range(255), $urandom_range(255),
                       $urandom_range(255), $urandom_range(255));
            @(negedge clk);
            checks++;
            if ({out, sample, peak} !== 18'd0) begin
                failures++;
                $display("FAIL reset_hold: out=%0d sample=%0b peak=%0b expected 0 0 0",
                         out, sample, peak);
            end
        end
        @(posedge clk);
        #1;
        set_inputs(100, 0, 0, 0, 16, 0, 0, 0);
        rst_n = 1'b1;
        wait_sample(ok, n);
        checks++;
        if (!ok || n != FRAME) begin
            failures++;
            $display("FAIL reset_latency: edges=%0d ok=%0b expected %0d", n, ok, FRAME);
        end
`ifdef JT89_MIX_LPF_EN
        exp_first = 100;
`else
        exp_first = 400;
`endif
        checks++;
        if (out !== 16'(exp_first) || peak !== 1'b0) begin
            failures++;
            $display("FAIL reset_first_out: out=%0d peak=%0b expected %0d 0", out, peak, exp_first);
        end
    endtask

    task automatic test_single_channel();
        bit ok;
        int n;
`ifdef JT89_MIX_LPF_EN
        int exp_v[3] = '{175, 231, 273};
`else
        int exp_v[3] = '{400, 400, 400};
`endif
        for (int k = 0; k < 3; k++) begin
            wait_sample(ok, n);
            checks++;
            if (!ok || n != FRAME || out !== 16'(exp_v[k]) || peak !== 1'b0) begin
                failures++;
                $display("FAIL single_ch[%0d]: out=%0d period=%0d peak=%0b expected %0d period=%0d peak=0",
                         k, out, n, peak, exp_v[k], FRAME);
            end
        end
    endtask

    task automatic test_saturation();
        bit ok;
        int n;
        int exp_o[3] = '{32767, -32768, 0};
        bit exp_p[3] = '{1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 3; k++) begin
            #1;
            case (k)
                0:       set_inputs(511, 511, 511, 511, 255, 255, 255, 255);
                1:       set_inputs(-512, -512, -512, -512, 255, 255, 255, 255);
                default: set_inputs(-512, -512, -512, -512, 0, 0, 0, 0);
            endcase
            wait_sample(ok, n);
            checks++;
            if (!ok || peak !== exp_p[k]) begin
                failures++;
                $display("FAIL sat_peak[%0d]: peak=%0b ok=%0b expected %0b", k, peak, ok, exp_p[k]);
            end
`ifndef JT89_MIX_LPF_EN
            checks++;
            if (out !== 16'(exp_o[k])) begin
                failures++;
                $display("FAIL sat_out[%0d]: out=%0d expected %0d", k, out, exp_o[k]);
            end
`endif
        end
    endtask

    task automatic test_cancel_snapshot();
        bit ok;
        int n;
        #1;
        set_inputs(200, -200, 37, -91, 16, 16, 0, 0);
        wait_sample(ok, n);
`ifndef JT89_MIX_LPF_EN
        checks++;
        if (!ok || out !== 16'sd0) begin
            failures++;
            $display("FAIL cancel: out=%0d expected 0", out);
        end
`endif
        // SNAP edge, then MAC0->MAC1 edge: now inside MAC1
        @(posedge clk);
        @(posedge clk);
        #1;
        ch0 = 10'sd300;
        wait_sample(ok, n);
`ifndef JT89_MIX_LPF_EN
        checks++;
        if (!ok || out !== 16'sd0) begin
            failures++;
            $display("FAIL snapshot_hold: out=%0d expected 0", out);
        end
`endif
        wait_sample(ok, n);
        checks++;
        if (!ok || n != FRAME) begin
            failures++;
            $display("FAIL snapshot_period: period=%0d expected %0d", n, FRAME);
        end
`ifndef JT89_MIX_LPF_EN
        checks++;
        if (out !== 16'sd400) begin
            failures++;
            $display("FAIL snapshot_next: out=%0d expected 400", out);
        end
`endif
    endtask

    task automatic test_cen_gating();
        bit ok;
        int n;
        #1;
        set_inputs(100, 0, 0, 0, 16, 0, 0, 0);
        cen_mode = 1;
        for (int k = 0; k < 3; k++) begin
            wait_sample(ok, n);
            checks++;
            if (!ok || (k > 0 && n != 3 * FRAME)) begin
                failures++;
                $display("FAIL cen_period[%0d]: period=%0d ok=%0b expected %0d", k, n, ok, 3 * FRAME);
            end
`ifndef JT89_MIX_LPF_EN
            checks++;
            if (out !== 16'sd400) begin
                failures++;
                $display("FAIL cen_out[%0d]: out=%0d expected 400", k, out);
            end
`endif
        end
        cen_mode = 0;
    endtask

    task automatic test_mid_reset();
        bit ok;
        int n;
        int exp_v;
        wait_sample(ok, n);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out, sample, peak} !== 18'd0) begin
            failures++;
            $display("FAIL mid_reset_async: out=%0d sample=%0b peak=%0b expected 0 0 0",
                     out, sample, peak);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_sample(ok, n);
`ifdef JT89_MIX_LPF_EN
        exp_v = 100;
`else
        exp_v = 400;
`endif
        checks++;
        if (!ok || n != FRAME || out !== 16'(exp_v)) begin
            failures++;
            $display("FAIL mid_reset_recover: out=%0d edges=%0d expected %0d edges=%0d",
                     out, n, exp_v, FRAME);
        end
    endtask

    initial begin
        test_reset();
        test_single_channel();
        test_saturation();
        test_cancel_snapshot();
        test_cen_gating();
        test_mid_reset();
        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/jt89_mixer.md
Name: jt89_mixer

Overview:
- Downstream consumer of the jt89 PSG core outputs ch0, ch1, ch2 and noise, each signed 10-bit.
- Snapshots all four channels, applies a per-channel unsigned 8-bit gain and accumulates them serially with one shared multiplier.
- Emits one saturated signed 16-bit mixed sample per frame, with a one-cycle sample strobe and a clip flag.
- Sits between jt89 and the system audio path or DAC.

Parameters:
SHIFT, 2, arithmetic right shift applied to the 20-bit accumulator before saturation (legal 0..4)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
cen  input  1  clock enable; all state advances only when cen=1
ch0  input  10  signed tone channel 0
ch1  input  10  signed tone channel 1
ch2  input  10  signed tone channel 2
noise  input  10  signed noise channel
gain0  input  8  unsigned gain for ch0 (0 = mute)
gain1  input  8  unsigned gain for ch1
gain2  input  8  unsigned gain for ch2
gain3  input  8  unsigned gain for noise
out  output  16  signed mixed sample, registered
sample  output  1  high for exactly one clk when out updates
peak  output  1  high with sample when that sample saturated

Behaviour:
- Reset (rst_n=0, asynchronous):
  - out=0, sample=0, peak=0.
  - Accumulator and snapshot registers cleared; FSM forced to SNAP.
  - Release is synchronous to clk.
- FSM states: SNAP -> MAC0 -> MAC1 -> MAC2 -> MAC3 -> SNAP.
  - One transition per clk with cen=1; with cen=0 everything holds and sample=0.
- SNAP:
  - Latch ch0/ch1/ch2/noise and gain0..gain3 into snapshot registers.
  - Clear accumulator.
  - Input changes after this edge do not affect the current frame.
- MACk:
  - acc <= acc + snap_chk * snap_gaink.
  - Gain is zero-extended to 9-bit signed; product is 18-bit signed; accumulator is 20-bit signed.
  - Accumulator range: max +521220, min -522240, so no internal overflow is possible.
- MAC3 -> SNAP transition:
  - res = (acc + product3) >>> SHIFT, using the final sum.
  - out <= res saturated to [-32768, 32767].
  - sample=1 for that single clk.
  - peak=1 in the same clk iff saturation occurred; otherwise peak=0.
  - sample and peak are 0 on every other clk.
- Frame period: 5 cen-qualified clocks. Latency from SNAP edge to out update: 5 cen edges.
- cen held high continuously gives a sample every 5 clk. Irregular cen stretches the frame without corrupting it.
- out holds its value between strobes.
- Reset mid-frame: partial accumulation is discarded; the first sample after release comes 5 cen edges later.

Optional Feature:
Macro: JT89_MIX_LPF_EN
- Defined:
  - Adds FILT state between MAC3 and SNAP; frame becomes 6 cen edges.
  - In MAC3 the saturated value x is stored.
  - In FILT: y <= y + ((x - y) >>> 2), with y an 18-bit signed register reset to 0.
  - out <= y, and sample/peak pulse on the FILT -> SNAP transition. peak reflects saturation of x.
- Not defined:
  - FILT state and y do not exist; 5-edge frame as above.

Test Plan:
1. Reset: hold rst_n=0 with random inputs and cen=1 -> out=0, sample=0, peak=0. Release rst_n -> first sample pulse exactly 5 cen edges later.
2. Single channel: ch0=100, gain0=16, other gains 0, SHIFT=2, cen=1 -> out=400, peak=0, sample every 5 clk. With JT89_MIX_LPF_EN: successive outs 100, 175, 231, 273, period 6 clk.
3. Saturation, both rails:
   - All channels 511, all gains 255 -> out=32767, peak=1.
   - All channels -512, all gains 255 -> out=-32768, peak=1.
   - Then all gains 0 -> out=0, peak=0.
4. Cancellation and snapshot: ch0=200, ch1=-200, gain0=gain1=16 -> out=0.
   - Change ch0 to 300 during MAC1 -> current frame out=0; next frame out=(300-200)*16>>>2=400.
5. cen gating: cen=1 one clk in three -> sample period 15 clk, values identical to scenario 2. sample never asserted while cen=0.
6. Mid-frame reset: assert rst_n=0 during MAC2 with scenario 2 inputs -> out=0 immediately (asynchronous). After release -> out=400 after 5 cen edges, no stale partial sum.
